// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for the five-stage RV32I pipeline.
// Joins the I-cache and D-cache handshakes into one advance decision and
// produces the pipeline register enables and flushes for that cycle. It also
// inserts load-use bubbles and squashes wrong-path work on EX redirects.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_resp,
    output logic             imem_read,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             dmem_go,
    input  logic             branch_taken,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    // A done flag remembers a cache that already answered while the other
    // one is still busy, so its response is not lost and it is not re-requested.
    logic imem_done, dmem_done;
    logic imem_ready, dmem_ready, advance, hazard;
    logic stall, redirect, bubble;

    // Handshake join and load-use hazard detection.
    always_comb begin
        imem_ready = imem_resp | imem_done;
        dmem_ready = ~dmem_req | dmem_resp | dmem_done;
        advance    = imem_ready & dmem_ready;
        hazard     = idex_mem_read & (idex_rd != 5'd0) &
                     ((ifid_use_rs1 & (ifid_rs1 == idex_rd)) |
                      (ifid_use_rs2 & (ifid_rs2 == idex_rd)));
        stall      = ~advance;
        redirect   = advance & branch_taken;
        bubble     = advance & ~branch_taken & hazard;
    end

    // Control outputs; everything is forced low while reset is held.
    always_comb begin
        imem_read   = 1'b0;
        dmem_go     = 1'b0;
        pc_en       = 1'b0;
        pc_redirect = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        if (rst_n) begin
            imem_read = ~imem_done;
            dmem_go   = dmem_req & ~dmem_done;
            if (redirect) begin
                pc_en       = 1'b1;
                pc_redirect = 1'b1;
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
            end else if (bubble) begin
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (!stall) begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    // Done flags: cleared on advance, otherwise latch each response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_done <= 1'b0;
            dmem_done <= 1'b0;
        end else if (advance) begin
            imem_done <= 1'b0;
            dmem_done <= 1'b0;
        end else begin
            imem_done <= imem_done | imem_resp;
            dmem_done <= dmem_done | dmem_resp;
        end
    end

    // Performance counters, free-running modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count  <= '0;
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (stall)    stall_count  <= stall_count + CNT_W'(1);
            if (bubble)   bubble_count <= bubble_count + CNT_W'(1);
            if (redirect) flush_count  <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios followed by randomized
// traffic, checked every cycle against a transaction-level reference model.
// A second instance with 4-bit counters covers counter wrap.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic imem_resp = 0, dmem_req = 0, dmem_resp = 0, branch_taken = 0;
    logic idex_mem_read = 0, ifid_use_rs1 = 0, ifid_use_rs2 = 0;
    logic [4:0] idex_rd = 0, ifid_rs1 = 0, ifid_rs2 = 0;

    logic imem_read, dmem_go, pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush;
    logic [31:0] stall_count, bubble_count, flush_count;

    logic imem_read4, dmem_go4, pc_en4, pc_redirect4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
    logic ifid_flush4, idex_flush4;
    logic [3:0] stall_count4, bubble_count4, flush_count4;

    pipeline_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .imem_read(imem_read),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .dmem_go(dmem_go),
        .branch_taken(branch_taken), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
        .ifid_use_rs2(ifid_use_rs2), .pc_en(pc_en), .pc_redirect(pc_redirect),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .stall_count(stall_count),
        .bubble_count(bubble_count), .flush_count(flush_count)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .imem_read(imem_read4),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .dmem_go(dmem_go4),
        .branch_taken(branch_taken), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1),
        .ifid_use_rs2(ifid_use_rs2), .pc_en(pc_en4), .pc_redirect(pc_redirect4),
        .ifid_en(ifid_en4), .idex_en(idex_en4), .exmem_en(exmem_en4), .memwb_en(memwb_en4),
        .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .stall_count(stall_count4),
        .bubble_count(bubble_count4), .flush_count(flush_count4)
    );

    always #5 clk = ~clk;

    // {pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, imem_read, dmem_go}
    wire [9:0] ctl  = {pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, imem_read, dmem_go};
    wire [9:0] ctl4 = {pc_en4, pc_redirect4, ifid_en4, idex_en4, exmem_en4, memwb_en4,
                       ifid_flush4, idex_flush4, imem_read4, dmem_go4};

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: which cache answers have been collected for the
    // transaction in flight, plus event tallies.
    bit     fetch_seen, mem_seen;
    longint n_stall, n_bubble, n_flush;

    function automatic bit m_stalled();
        bit fetch_ok, mem_ok;
        fetch_ok = imem_resp || fetch_seen;
        mem_ok   = !dmem_req || dmem_resp || mem_seen;
        return !(fetch_ok && mem_ok);
    endfunction

    function automatic bit m_hazard();
        logic [4:0] src[2];
        bit         use_src[2];
        bit         hit = 0;
        src[0] = ifid_rs1; src[1] = ifid_rs2;
        use_src[0] = ifid_use_rs1; use_src[1] = ifid_use_rs2;
        for (int k = 0; k < 2; k++)
            if (use_src[k] && src[k] == idex_rd) hit = 1;
        return idex_mem_read && idex_rd != 0 && hit;
    endfunction

    function automatic logic [9:0] m_ctl();
        bit rd = !fetch_seen;
        bit go = dmem_req && !mem_seen;
        if (m_stalled())        return {8'b0000_0000, rd, go};
        else if (branch_taken)  return {8'b1111_1111, rd, go};
        else if (m_hazard())    return {8'b0001_1101, rd, go};
        else                    return {8'b1011_1100, rd, go};
    endfunction

    task automatic model_reset();
        fetch_seen = 0; mem_seen = 0;
        n_stall = 0; n_bubble = 0; n_flush = 0;
    endtask

    // One clock cycle: inputs already driven at the negedge.
    task automatic run_cycle(input string tag);
        #2;
        check_eq({tag, ".ctl"},    ctl,  m_ctl());
        check_eq({tag, ".ctl4"},   ctl4, m_ctl());
        check_eq({tag, ".stall"},  stall_count,  n_stall  & 64'hFFFF_FFFF);
        check_eq({tag, ".bubble"}, bubble_count, n_bubble & 64'hFFFF_FFFF);
        check_eq({tag, ".flush"},  flush_count,  n_flush  & 64'hFFFF_FFFF);
        check_eq({tag, ".stall4"}, stall_count4, n_stall % 16);
        @(posedge clk);
        if (m_stalled()) begin
            n_stall++;
            if (imem_resp) fetch_seen = 1;
            if (dmem_resp) mem_seen = 1;
        end else begin
            fetch_seen = 0; mem_seen = 0;
            if (branch_taken)    n_flush++;
            else if (m_hazard()) n_bubble++;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_eq({tag, ".ctl"},    ctl, 10'd0);
        check_eq({tag, ".ctl4"},   ctl4, 10'd0);
        check_eq({tag, ".cnt"},    {stall_count, bubble_count}, 64'd0);
        check_eq({tag, ".flush"},  flush_count, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic clear_id();
        branch_taken = 0; idex_mem_read = 0; idex_rd = 0;
        ifid_rs1 = 0; ifid_rs2 = 0; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
    endtask

    longint base;

    initial begin
        model_reset();
        #3;
        check_eq("por.ctl", ctl, 10'd0);
        check_eq("por.cnt", {stall_count, bubble_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch every cycle, no memory traffic.
        imem_resp = 1; dmem_req = 0;
        for (int i = 0; i < 5; i++) run_cycle("stream");
        check_eq("stream.zero", {stall_count, flush_count}, 64'd0);

        // I-cache answers after three wait cycles.
        base = n_stall;
        imem_resp = 0;
        for (int i = 0; i < 3; i++) run_cycle("iwait");
        imem_resp = 1;
        run_cycle("iwait.adv");
        check_eq("iwait.stall3", stall_count - base[31:0], 64'd3);

        // Fetch done first, data later.
        dmem_req = 1; imem_resp = 1; dmem_resp = 0;
        run_cycle("dm.c1");
        imem_resp = 0;
        run_cycle("dm.c2");
        check_eq("dm.c2.imem_read", imem_read, 1'b0);
        run_cycle("dm.c3");
        dmem_resp = 1;
        run_cycle("dm.c4");
        dmem_resp = 0; dmem_req = 0; imem_resp = 1;
        run_cycle("dm.c5");
        check_eq("dm.c5.imem_read", imem_read, 1'b1);

        // Load-use hazard on rs2.
        base = n_bubble;
        idex_mem_read = 1; idex_rd = 5; ifid_rs2 = 5; ifid_use_rs2 = 1;
        run_cycle("lu.hit");
        clear_id();
        run_cycle("lu.after");
        check_eq("lu.bubble1", bubble_count - base[31:0], 64'd1);
        idex_mem_read = 1; idex_rd = 0; ifid_rs2 = 0; ifid_use_rs2 = 1;
        run_cycle("lu.x0");
        clear_id();
        check_eq("lu.x0.nobubble", bubble_count - base[31:0], 64'd1);

        // Redirect wins over the same hazard.
        base = n_bubble;
        idex_mem_read = 1; idex_rd = 5; ifid_rs2 = 5; ifid_use_rs2 = 1; branch_taken = 1;
        run_cycle("br");
        clear_id();
        run_cycle("br.after");
        check_eq("br.flush1", flush_count, 64'd1);
        check_eq("br.nobubble", bubble_count - base[31:0], 64'd0);

        // Counter wrap on the 4-bit instance.
        apply_reset("rst2");
        imem_resp = 0; dmem_req = 0;
        for (int i = 0; i < 17; i++) run_cycle("wrap");
        check_eq("wrap.stall4", stall_count4, 64'd1);
        check_eq("wrap.stall32", stall_count, 64'd17);

        // Reset in the middle of a stall with the fetch flag set.
        imem_resp = 1; dmem_req = 1; dmem_resp = 0;
        run_cycle("mid.c1");
        imem_resp = 0;
        run_cycle("mid.c2");
        apply_reset("mid.rst");
        imem_resp = 0; dmem_req = 0;
        run_cycle("mid.refetch");
        check_eq("mid.imem_read", imem_read, 1'b1);
        imem_resp = 1;
        run_cycle("mid.adv");

        // Randomized traffic; ID/EX inputs only change once the pipe advances.
        for (int i = 0; i < 600; i++) begin
            bit was_stalled;
            was_stalled = m_stalled();
            if (!was_stalled || i == 0) begin
                dmem_req      = ($urandom_range(0, 2) == 0);
                branch_taken  = ($urandom_range(0, 5) == 0);
                idex_mem_read = $urandom_range(0, 1);
                idex_rd       = 5'($urandom_range(0, 3));
                ifid_rs1      = 5'($urandom_range(0, 3));
                ifid_rs2      = 5'($urandom_range(0, 3));
                ifid_use_rs1  = $urandom_range(0, 1);
                ifid_use_rs2  = $urandom_range(0, 1);
            end
            imem_resp = ($urandom_range(0, 2) != 0);
            dmem_resp = dmem_req && ($urandom_range(0, 2) == 0);
            run_cycle("rand");
            if (i == 300) begin
                apply_reset("rand.rst");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
